// File: rtl/core_run_pkg.sv
// Shared types and constants for the RV32I run controller.
package core_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_ECALL   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_STOP    = 3'd4;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

endpackage

// File: rtl/core_run_ctrl.sv
// Run controller: loads the instruction image, then holds/releases the core in reset
// and records why, where and after how many cycles it halted.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int unsigned CYC_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              stop_req,
  input  logic              halt_ack,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       core_instruction,
  input  logic [31:0]       core_pc,
  input  logic              core_write,
  output logic              core_rst,
  output logic              dmem_we,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [31:0]       halt_pc,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   load_words,
  output logic              load_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                ovf_q, ovf_d;
  logic [CYC_W-1:0]    cycle_q, cycle_d;
  logic [CYC_W-1:0]    max_q, max_d;
  logic [2:0]          cause_q, cause_d;
  logic [31:0]         halt_pc_q, halt_pc_d;
  logic [2:0]          cause_now;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    words_d   = words_q;
    ovf_d     = ovf_q;
    cycle_d   = cycle_q;
    max_d     = max_q;
    cause_d   = cause_q;
    halt_pc_d = halt_pc_q;
    cause_now = CAUSE_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          words_d = '0;
          ovf_d   = 1'b0;
        end else if (run_start) begin
          state_d = ST_RUN;
          cycle_d = '0;
          max_d   = max_cycles;
          cause_d = CAUSE_NONE;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          words_d = words_q + (ADDR_W+1)'(1);
          if (ld_last) begin
            state_d = ST_IDLE;
          end else if (ptr_q == LAST_ADDR) begin
            ovf_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        cycle_d = (&cycle_q) ? cycle_q : cycle_q + CYC_W'(1);
        // Priority order: EBREAK, ECALL, timeout, host stop.
        if (core_instruction == INSTR_EBREAK)
          cause_now = CAUSE_EBREAK;
        else if (core_instruction == INSTR_ECALL)
          cause_now = CAUSE_ECALL;
        else if ((max_q != '0) && (cycle_q == max_q - CYC_W'(1)))
          cause_now = CAUSE_TIMEOUT;
        else if (stop_req)
          cause_now = CAUSE_STOP;
        if (cause_now != CAUSE_NONE) begin
          cause_d   = cause_now;
          halt_pc_d = core_pc;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (halt_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      words_q   <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
      max_q     <= '0;
      cause_q   <= CAUSE_NONE;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      words_q   <= words_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      max_q     <= max_d;
      cause_q   <= cause_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign ld_ready      = (state_q == ST_LOAD);
  assign imem_we       = ld_valid & ld_ready;
  assign imem_addr     = ptr_q;
  assign imem_wdata    = ld_data;
  assign core_rst      = (state_q != ST_RUN);
  assign dmem_we       = core_write & (state_q == ST_RUN);
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign halted        = (state_q == ST_DONE);
  assign halt_cause    = cause_q;
  assign halt_pc       = halt_pc_q;
  assign cycle_count   = cycle_q;
  assign load_words    = words_q;
  assign load_overflow = ovf_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl (IMEM_DEPTH=8) with a behavioural reference model.
module tb_core_run_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL0   = 32'h0000_006f;

  logic clk = 0;
  logic rst = 1;
  logic load_start = 0, run_start = 0, stop_req = 0, halt_ack = 0;
  logic [31:0] max_cycles = '0;
  logic ld_valid = 0, ld_last = 0;
  logic [31:0] ld_data = '0;
  logic ld_ready, imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] core_instruction = NOP, core_pc = '0;
  logic core_write = 0;
  logic core_rst, dmem_we, busy, halted;
  logic [2:0] halt_cause;
  logic [31:0] halt_pc, cycle_count;
  logic [AW:0] load_words;
  logic load_overflow;

  core_run_ctrl #(.IMEM_DEPTH(DEPTH), .CYC_W(32)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
    .stop_req(stop_req), .halt_ack(halt_ack), .max_cycles(max_cycles),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_instruction(core_instruction), .core_pc(core_pc), .core_write(core_write),
    .core_rst(core_rst), .dmem_we(dmem_we), .busy(busy), .halted(halted),
    .halt_cause(halt_cause), .halt_pc(halt_pc), .cycle_count(cycle_count),
    .load_words(load_words), .load_overflow(load_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] img(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Reference model: tracks what the controller must be doing from the rules alone.
  int          m_mode = M_IDLE;
  longint      m_cyc = 0, m_max = 0, m_words = 0;
  bit          m_ovf = 0;
  int          m_cause = 0;
  logic [31:0] m_pc = '0;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_cyc = 0; m_max = 0; m_words = 0; m_ovf = 0; m_cause = 0; m_pc = '0;
    end else begin
      case (m_mode)
        M_IDLE:
          if (load_start) begin
            m_mode = M_LOAD; m_words = 0; m_ovf = 0;
          end else if (run_start) begin
            m_mode = M_RUN; m_cyc = 0; m_max = max_cycles; m_cause = 0;
          end
        M_LOAD:
          if (ld_valid) begin
            m_words++;
            if (ld_last) m_mode = M_IDLE;
            else if (m_words == DEPTH) begin m_ovf = 1; m_mode = M_IDLE; end
          end
        M_RUN: begin
          int c;
          if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
          c = 0;
          if (core_instruction == EBREAK) c = 1;
          else if (core_instruction == ECALL) c = 2;
          else if (m_max != 0 && m_cyc == m_max) c = 3;
          else if (stop_req) c = 4;
          if (c != 0) begin m_cause = c; m_pc = core_pc; m_mode = M_DONE; end
        end
        default:
          if (halt_ack) m_mode = M_IDLE;
      endcase
    end
    started = 1;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      check("core_rst", core_rst, m_mode != M_RUN);
      check("ld_ready", ld_ready, m_mode == M_LOAD);
      check("busy", busy, m_mode == M_LOAD || m_mode == M_RUN);
      check("halted", halted, m_mode == M_DONE);
      check("halt_cause", halt_cause, m_cause);
      check("halt_pc", halt_pc, m_pc);
      check("cycle_count", cycle_count, m_cyc);
      check("load_words", load_words, m_words);
      check("load_overflow", load_overflow, m_ovf);
      check("imem_we", imem_we, m_mode == M_LOAD && ld_valid);
      check("dmem_we", dmem_we, m_mode == M_RUN && core_write);
      if (m_mode == M_LOAD) check("imem_addr", imem_addr, m_words % DEPTH);
      if (imem_we) check("imem_wdata", imem_wdata, ld_data);
    end
  end

  logic [31:0] mem_cap [DEPTH];
  int wr_count = 0;
  always @(posedge clk) if (imem_we) begin mem_cap[imem_addr] = imem_wdata; wr_count++; end

  task automatic do_load(input int n, input int last_idx, input bit bubbles);
    int sent = 0;
    int t = 0;
    bit hs;
    wr_count = 0;
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
    while (ld_ready && t < 200) begin
      ld_valid = (bubbles && (t % 2 == 1)) ? 1'b0 : (sent < n);
      ld_data  = img(sent);
      ld_last  = (sent == last_idx);
      hs = ld_valid && ld_ready;
      @(negedge clk);
      t++;
      if (hs) sent++;
    end
    ld_valid = 0; ld_last = 0;
    if (t >= 200) check("load_timeout", 1, 0);
  endtask

  task automatic run_prog(input logic [31:0] maxc, input int halt_at, input logic [31:0] halt_instr,
                          input int stop_at, input bit loop_prog);
    bit done = 0;
    @(negedge clk) begin run_start = 1; max_cycles = maxc; end
    @(negedge clk) run_start = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      core_pc          = loop_prog ? 32'h40 : 32'(4 * (k - 1));
      core_instruction = (k == halt_at) ? halt_instr : (loop_prog ? JAL0 : NOP);
      stop_req         = (k == stop_at);
      if (k == 1) begin #1; check("dmem_we_run", dmem_we, core_write); end
      @(posedge clk); #1;
      if (halted) done = 1;
      else @(negedge clk);
    end
    if (!done) check("run_timeout", 1, 0);
    @(negedge clk) begin stop_req = 0; core_instruction = NOP; end
  endtask

  task automatic ack();
    @(negedge clk) halt_ack = 1;
    @(negedge clk) halt_ack = 0;
    check("ack_idle", {busy, halted, core_rst}, 3'b001);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;

    // Load of 4 words with bubbles
    do_load(4, 3, 1);
    check("load4_writes", wr_count, 4);
    check("load4_words", load_words, 4);
    check("load4_ovf", load_overflow, 0);
    for (int i = 0; i < 4; i++) check("load4_data", mem_cap[i], img(i));

    // Overflow: 9 words without ld_last
    do_load(9, -1, 0);
    check("ovf_writes", wr_count, 8);
    check("ovf_words", load_words, 8);
    check("ovf_flag", load_overflow, 1);
    check("ovf_idle", busy, 0);
    check("ovf_last_data", mem_cap[7], img(7));
    @(negedge clk) begin ld_valid = 1; ld_data = img(8); end
    repeat (3) @(negedge clk);
    ld_valid = 0;
    check("ovf_no_9th", wr_count, 8);

    // EBREAK at pc 8, stores active throughout
    core_write = 1;
    #1 check("dmem_we_idle", dmem_we, 0);
    run_prog(32'd0, 3, EBREAK, 0, 0);
    check("ebreak_cause", halt_cause, 1);
    check("ebreak_pc", halt_pc, 32'd8);
    check("ebreak_count", cycle_count, 3);
    check("ebreak_core_rst", core_rst, 1);
    check("dmem_we_done", dmem_we, 0);
    ack();
    check("hold_after_ack", halt_pc, 32'd8);

    // ECALL at cycle 2
    run_prog(32'd0, 2, ECALL, 0, 0);
    check("ecall_cause", halt_cause, 2);
    check("ecall_pc", halt_pc, 32'd4);
    ack();

    // Timeout, then timeout colliding with stop, then stop without timeout
    run_prog(32'd10, 0, NOP, 0, 1);
    check("tmo_cause", halt_cause, 3);
    check("tmo_count", cycle_count, 10);
    check("tmo_pc", halt_pc, 32'h40);
    ack();
    run_prog(32'd10, 0, NOP, 10, 1);
    check("tmo_stop_cause", halt_cause, 3);
    check("tmo_stop_count", cycle_count, 10);
    ack();
    run_prog(32'd0, 0, NOP, 5, 1);
    check("stop_cause", halt_cause, 4);
    check("stop_count", cycle_count, 5);
    ack();

    // Reset mid-RUN
    @(negedge clk) begin run_start = 1; max_cycles = 0; end
    @(negedge clk) run_start = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_run", core_rst, 0);
    rst = 1;
    @(posedge clk); #1;
    check("rst_core_rst", core_rst, 1);
    check("rst_count", cycle_count, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk) rst = 0;
    core_write = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
